// File: rtl/traffic_pkg.sv
// Shared types for the traffic light controller: FSM states, lamp codes and
// small helpers for phase sequencing and lamp decoding.
`timescale 1ns/1ps
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    SIDE_GREEN  = 3'd2,
    SIDE_YELLOW = 3'd3,
    NIGHT       = 3'd4
  } state_e;

  // Lamp vectors are {R,Y,G}
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Successor in the normal day cycle; NIGHT exits to MAIN_GREEN
  function automatic state_e next_phase(input state_e s);
    case (s)
      MAIN_GREEN:  return MAIN_YELLOW;
      MAIN_YELLOW: return SIDE_GREEN;
      SIDE_GREEN:  return SIDE_YELLOW;
      default:     return MAIN_GREEN;
    endcase
  endfunction

  // Main-road lamp for a state; flash_on selects Y vs dark in NIGHT
  function automatic logic [2:0] main_lamp(input state_e s, input logic flash_on);
    case (s)
      MAIN_GREEN:  return LAMP_G;
      MAIN_YELLOW: return LAMP_Y;
      SIDE_GREEN:  return LAMP_R;
      SIDE_YELLOW: return LAMP_R;
      default:     return flash_on ? LAMP_Y : LAMP_OFF;
    endcase
  endfunction

  // Side-road lamp for a state; flash_on selects Y vs dark in NIGHT
  function automatic logic [2:0] side_lamp(input state_e s, input logic flash_on);
    case (s)
      MAIN_GREEN:  return LAMP_R;
      MAIN_YELLOW: return LAMP_R;
      SIDE_GREEN:  return LAMP_G;
      SIDE_YELLOW: return LAMP_Y;
      default:     return flash_on ? LAMP_Y : LAMP_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts 0..CLK_DIV-1 while enabled and emits a
// registered one-cycle tick on the cycle after the terminal count.
`timescale 1ns/1ps
module tick_gen #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  // Next prescaler value: clear wins, otherwise count and wrap when enabled
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Prescaler and tick registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller with per-second countdown, pause and a
// flashing-yellow night mode. All outputs come straight from flops.
`timescale 1ns/1ps
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_DIV     = 50_000_000,
  parameter int GREEN_TIME  = 25,
  parameter int YELLOW_TIME = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause,
  input  logic       night_mode,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [5:0] count,
  output logic       sec_tick
);

  // Refuse to elaborate with out-of-range timing parameters
  if (CLK_DIV < 2 || CLK_DIV > (1 << 26)) begin : g_bad_div
    $fatal(1, "traffic_light_ctrl: CLK_DIV out of range 2..2^26");
  end
  if (GREEN_TIME < 1 || GREEN_TIME > 63) begin : g_bad_green
    $fatal(1, "traffic_light_ctrl: GREEN_TIME out of range 1..63");
  end
  if (YELLOW_TIME < 1 || YELLOW_TIME > 63) begin : g_bad_yellow
    $fatal(1, "traffic_light_ctrl: YELLOW_TIME out of range 1..63");
  end

  localparam logic [5:0] GREEN_CNT  = 6'(GREEN_TIME);
  localparam logic [5:0] YELLOW_CNT = 6'(YELLOW_TIME);

  state_e     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_d;
  logic       flash_q, flash_d;   // 1 = yellow lit during NIGHT
  logic       tick;
  logic       in_night;
  logic       tick_en;
  logic       tick_clr;

  // Restart the prescaler on every mode change; night ignores pause
  assign in_night = (state_q == NIGHT);
  assign tick_clr = (night_mode != in_night);
  assign tick_en  = night_mode | ~pause;

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // Next state, countdown and lamp decode; a tick already issued is consumed
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    flash_d = flash_q;
    if (night_mode) begin
      if (!in_night) begin
        state_d = NIGHT;
        count_d = 6'd0;
        flash_d = 1'b1;
      end else if (tick) begin
        flash_d = ~flash_q;
      end
    end else if (in_night) begin
      state_d = MAIN_GREEN;
      count_d = GREEN_CNT;
      flash_d = 1'b1;
    end else if (tick) begin
      if (count_q > 6'd1) begin
        count_d = count_q - 6'd1;
      end else begin
        state_d = next_phase(state_q);
        count_d = (state_d == MAIN_GREEN || state_d == SIDE_GREEN) ? GREEN_CNT : YELLOW_CNT;
      end
    end
    main_d = main_lamp(state_d, flash_d);
    side_d = side_lamp(state_d, flash_d);
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MAIN_GREEN;
      count_q <= GREEN_CNT;
      flash_q <= 1'b1;
      main_q  <= LAMP_G;
      side_q  <= LAMP_R;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      flash_q <= flash_d;
      main_q  <= main_d;
      side_q  <= side_d;
    end
  end

  assign main_light = main_q;
  assign side_light = side_q;
  assign count      = count_q;
  assign sec_tick   = tick;

endmodule
